// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit for the MIPS execute stage.
// Shift-add multiply, restoring divide; HI/LO only change on completion or mthi/mtlo.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  // Handshake: start is accepted only on a rising edge where the unit is IDLE;
  // busy rises the cycle after acceptance and falls when done pulses, and
  // start/mthi/mtlo presented while not IDLE are dropped without effect.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t             state_q;
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               is_div_q;
  logic               neg_q;
  logic               rem_neg_q;
  logic               div0_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [CW-1:0]      cnt_q;

  logic               in_signed;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     rem_diff;
  logic               rem_ge;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] acc_d;
  logic [2*WIDTH-1:0] prod_d;
  logic [WIDTH-1:0]   quo_d;
  logic [WIDTH-1:0]   rem_d;
  logic [WIDTH-1:0]   res_hi_d;
  logic [WIDTH-1:0]   res_lo_d;

  // Signed ops work on magnitudes; -2^(WIDTH-1) maps onto itself, which is
  // exactly its magnitude when read as unsigned.
  assign in_signed = ~op[0];
  assign a_mag     = (in_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
  assign b_mag     = (in_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
               {1'b0, (acc_q[0] ? mcand_q : {WIDTH{1'b0}})};
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, mcand_q};
    rem_ge   = (rem_sh >= {1'b0, mcand_q});
    div_next = {(rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                acc_q[WIDTH-2:0], rem_ge};

    acc_d    = is_div_q ? div_next : mul_next;
    prod_d   = neg_q ? (~acc_d + 1'b1) : acc_d;
    quo_d    = acc_d[WIDTH-1:0];
    rem_d    = acc_d[2*WIDTH-1:WIDTH];

    res_hi_d = prod_d[2*WIDTH-1:WIDTH];
    res_lo_d = prod_d[WIDTH-1:0];
    if (is_div_q) begin
      // A zero divisor leaves quotient all-ones and remainder = |a|; restoring
      // the dividend sign on the remainder gives back a unchanged.
      res_lo_d = (neg_q && !div0_q) ? (~quo_d + 1'b1) : quo_d;
      res_hi_d = rem_neg_q ? (~rem_d + 1'b1) : rem_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      div0_q    <= 1'b0;
      mcand_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_CALC;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            is_div_q  <= op[1];
            neg_q     <= in_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            rem_neg_q <= in_signed & a[WIDTH-1];
            div0_q    <= (b == '0);
            if (op[1]) begin
              mcand_q <= b_mag;
              acc_q   <= {{WIDTH{1'b0}}, a_mag};
            end else begin
              mcand_q <= a_mag;
              acc_q   <= {{WIDTH{1'b0}}, b_mag};
            end
          end else begin
            if (mthi) hi_q <= a;
            if (mtlo) lo_q <= a;
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
            state_q <= S_FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            hi_q    <= res_hi_d;
            lo_q    <= res_lo_d;
          end
        end
        S_FIN: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and random checks of mul_div_unit against an arithmetic reference
// model: results, latency, busy/done timing, mthi/mtlo and mid-op reset.
module tb_mul_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         mthi;
  logic         mtlo;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic [1:0]   dbg_state;

  int vectors     = 0;
  int miscompares = 0;

  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   exp_hi = '0;
  logic [W-1:0]   exp_lo = '0;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .mthi      (mthi),
    .mtlo      (mtlo),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard compare ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: plain 64-bit arithmetic; returns {hi, lo}.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      2'b00: begin
        p = sx * sy;
        return p;
      end
      2'b01: begin
        p = {32'b0, x} * {32'b0, y};
        return p;
      end
      2'b10: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom();
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic with_mt, input string tag);
    logic [63:0] e;
    int k;
    int bcnt;
    @(posedge clk); #1;
    check($sformatf("%s.idle_done", tag), 64'(done), 64'd0);
    start = 1'b1; op = o; a = x; b = y; mthi = with_mt; mtlo = with_mt;
    exp_q.push_back(model(o, x, y));
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    k = 0;
    bcnt = busy ? 1 : 0;
    while (!done && k < 60) begin
      @(posedge clk); #1;
      k++;
      if (busy) bcnt++;
      if (k == W / 2) begin
        check($sformatf("%s.hold_hi", tag), 64'(hi), 64'(exp_hi));
        check($sformatf("%s.hold_lo", tag), 64'(lo), 64'(exp_lo));
      end
    end
    check($sformatf("%s.latency", tag), 64'(k), 64'(W));
    check($sformatf("%s.busy_cycles", tag), 64'(bcnt), 64'(W));
    check($sformatf("%s.busy_at_done", tag), 64'(busy), 64'd0);
    check($sformatf("%s.done", tag), 64'(done), 64'd1);
    e = exp_q.pop_front();
    exp_hi = e[63:32];
    exp_lo = e[31:0];
    check($sformatf("%s.hi", tag), 64'(hi), 64'(exp_hi));
    check($sformatf("%s.lo", tag), 64'(lo), 64'(exp_lo));
  endtask

  task automatic move_to(input logic to_hi, input logic to_lo, input logic [31:0] x,
                         input string tag);
    @(posedge clk); #1;
    mthi = to_hi; mtlo = to_lo; a = x;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b0;
    if (to_hi) exp_hi = x;
    if (to_lo) exp_lo = x;
    check($sformatf("%s.hi", tag), 64'(hi), 64'(exp_hi));
    check($sformatf("%s.lo", tag), 64'(lo), 64'(exp_lo));
    check($sformatf("%s.done", tag), 64'(done), 64'd0);
    check($sformatf("%s.busy", tag), 64'(busy), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; mthi = 1'b0; mtlo = 1'b0;
    #12;
    check("reset.busy", 64'(busy), 64'd0);
    check("reset.done", 64'(done), 64'd0);
    check("reset.hi", 64'(hi), 64'd0);
    check("reset.lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
    check("multu_max.const_hi", 64'(hi), 64'hFFFF_FFFE);
    check("multu_max.const_lo", 64'(lo), 64'h0000_0001);
    run_op(2'b00, 32'hFFFF_FFF9, 32'd3, 1'b0, "mult_neg7x3");
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, "mult_minxmin");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_neg7by2");
    run_op(2'b11, 32'd100, 32'd7, 1'b0, "divu_100by7");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_min_by_m1");
    check("div_min_by_m1.const_lo", 64'(lo), 64'h8000_0000);
    run_op(2'b11, 32'h0000_1234, 32'd0, 1'b0, "divu_by0");
    run_op(2'b10, 32'hFFFF_FF00, 32'd0, 1'b0, "div_neg_by0");

    move_to(1'b0, 1'b1, 32'hDEAD_BEEF, "mtlo");
    move_to(1'b1, 1'b1, 32'h1357_9BDF, "mthi_mtlo");
    // start beside mthi/mtlo in IDLE: the operation wins
    run_op(2'b11, 32'd50, 32'd8, 1'b1, "start_prio");

    // start+mthi while busy are dropped; reset mid-op clears immediately
    @(posedge clk); #1;
    start = 1'b1; op = 2'b01; a = 32'd5; b = 32'd6;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    start = 1'b1; mthi = 1'b1; a = 32'd9;
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0;
    check("busy_ign.busy", 64'(busy), 64'd1);
    check("busy_ign.hi", 64'(hi), 64'(exp_hi));
    check("busy_ign.lo", 64'(lo), 64'(exp_lo));
    repeat (8) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    exp_hi = '0;
    exp_lo = '0;
    check("midreset.busy", 64'(busy), 64'd0);
    check("midreset.done", 64'(done), 64'd0);
    check("midreset.hi", 64'(hi), 64'd0);
    check("midreset.lo", 64'(lo), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op(2'b01, 32'd5, 32'd6, 1'b0, "after_reset");

    for (int i = 0; i < 30; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;
      ro = 2'($urandom_range(0, 3));
      ra = pick();
      rb = pick();
      run_op(ro, ra, rb, 1'b0, $sformatf("rand%0d_op%0d", i, ro));
    end

    @(posedge clk); #1;
    check("final.done", 64'(done), 64'd0);
    check("final.busy", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
